// File: rtl/vga_frame_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared VGA 640x480@60 timing and 320x240 RGB444 frame-buffer
//               constants plus a small counter-window helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int C_H_ACTIVE = 640;
    localparam int C_H_FP     = 16;
    localparam int C_H_SYNC   = 96;
    localparam int C_H_BP     = 48;
    localparam int C_H_TOTAL  = C_H_ACTIVE + C_H_FP + C_H_SYNC + C_H_BP;

    localparam int C_V_ACTIVE = 480;
    localparam int C_V_FP     = 10;
    localparam int C_V_SYNC   = 2;
    localparam int C_V_BP     = 33;
    localparam int C_V_TOTAL  = C_V_ACTIVE + C_V_FP + C_V_SYNC + C_V_BP;

    localparam int C_FB_WIDTH  = 320;
    localparam int C_FB_HEIGHT = 240;
    localparam int C_FB_PIXELS = C_FB_WIDTH * C_FB_HEIGHT;

    localparam int C_CNT_W  = 10;
    localparam int C_ADDR_W = 17;
    localparam int C_RGB_W  = 12;
    localparam int C_CH_W   = 4;
    localparam int C_R_LSB  = 8;
    localparam int C_G_LSB  = 4;
    localparam int C_B_LSB  = 0;

    function automatic logic in_window(input logic [C_CNT_W-1:0] cnt,
                                       input int start, input int len);
        return (int'(cnt) >= start) && (int'(cnt) < start + len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_frame_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_reader_if
// Description : Frame-buffer read port and VGA output bundle of the reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_frame_reader_if;
    import vga_pkg::*;

    logic [C_ADDR_W-1:0] bram_rd_addr;
    logic                bram_en;
    logic [C_RGB_W-1:0]  bram_rd_data;
    logic [C_CH_W-1:0]   vga_r;
    logic [C_CH_W-1:0]   vga_g;
    logic [C_CH_W-1:0]   vga_b;
    logic                vga_hsync;
    logic                vga_vsync;
    logic                vga_de;
    logic                frame_start;

    modport master (
        output bram_rd_addr, bram_en,
        input  bram_rd_data,
        output vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_de, frame_start
    );

    modport slave (
        input  bram_rd_addr, bram_en,
        output bram_rd_data,
        input  vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_de, frame_start
    );

endinterface
`default_nettype wire

// File: rtl/vga_frame_reader_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Horizontal/vertical counters with raw sync, active-video and
//               frame-start decodes (pipeline stage 0).
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = C_H_ACTIVE,
    parameter int H_FP     = C_H_FP,
    parameter int H_SYNC   = C_H_SYNC,
    parameter int H_BP     = C_H_BP,
    parameter int V_ACTIVE = C_V_ACTIVE,
    parameter int V_FP     = C_V_FP,
    parameter int V_SYNC   = C_V_SYNC,
    parameter int V_BP     = C_V_BP
) (
    input  logic               clk,
    input  logic               rst,
    output logic [C_CNT_W-2:0] o_col,
    output logic               o_v_active,
    output logic               o_v_odd,
    output logic               o_line_end,
    output logic               o_frame_end,
    output logic               o_de,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int VS_START = V_ACTIVE + V_FP;

    logic [C_CNT_W-1:0] r_h_cnt;
    logic [C_CNT_W-1:0] r_v_cnt;
    logic               w_h_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (o_line_end) begin
            r_h_cnt <= '0;
            r_v_cnt <= o_frame_end ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign o_line_end  = (r_h_cnt == C_CNT_W'(H_TOTAL - 1));
    assign o_frame_end = o_line_end && (r_v_cnt == C_CNT_W'(V_TOTAL - 1));
    assign w_h_active  = (r_h_cnt < C_CNT_W'(H_ACTIVE));
    assign o_v_active  = (r_v_cnt < C_CNT_W'(V_ACTIVE));
    assign o_v_odd     = r_v_cnt[0];
    assign o_de        = w_h_active && o_v_active;
    assign o_hsync     = !in_window(r_h_cnt, HS_START, H_SYNC);
    assign o_vsync     = !in_window(r_v_cnt, VS_START, V_SYNC);
    assign o_col       = r_h_cnt[C_CNT_W-1:1];

    // Gated by reset so the pulse stays low while the counters sit at origin in reset.
    assign o_frame_start = !rst && (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/vga_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_reader
// Description : Reads the 320x240 RGB444 frame buffer and drives 640x480 VGA
//               with 2x2 pixel replication and BRAM-latency-aligned syncs.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = C_H_ACTIVE,
    parameter int H_FP     = C_H_FP,
    parameter int H_SYNC   = C_H_SYNC,
    parameter int H_BP     = C_H_BP,
    parameter int V_ACTIVE = C_V_ACTIVE,
    parameter int V_FP     = C_V_FP,
    parameter int V_SYNC   = C_V_SYNC,
    parameter int V_BP     = C_V_BP,
    parameter int FB_WIDTH = C_FB_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    vga_frame_reader_if.master bus
);

    logic [C_CNT_W-2:0]  w_col;
    logic                w_v_active;
    logic                w_v_odd;
    logic                w_line_end;
    logic                w_frame_end;
    logic                w_de;
    logic                w_hsync;
    logic                w_vsync;
    logic                w_frame_start;

    logic [C_ADDR_W-1:0] r_line_base;
    logic [C_ADDR_W-1:0] r_rd_addr;
    logic                r_en;
    logic                r_de1, r_hs1, r_vs1;
    logic                r_de2, r_hs2, r_vs2;
    logic                r_de3, r_hs3, r_vs3;
    logic [C_RGB_W-1:0]  r_rgb;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk           (clk),
        .rst           (rst),
        .o_col         (w_col),
        .o_v_active    (w_v_active),
        .o_v_odd       (w_v_odd),
        .o_line_end    (w_line_end),
        .o_frame_end   (w_frame_end),
        .o_de          (w_de),
        .o_hsync       (w_hsync),
        .o_vsync       (w_vsync),
        .o_frame_start (w_frame_start)
    );

    // Advancing only after odd active lines shows each stored line twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line_base <= '0;
        end else if (w_frame_end) begin
            r_line_base <= '0;
        end else if (w_line_end && w_v_active && w_v_odd) begin
            r_line_base <= r_line_base + C_ADDR_W'(FB_WIDTH);
        end
    end

    // Stage 1: address issue and first sync delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_addr <= '0;
            r_en      <= 1'b0;
            r_de1     <= 1'b0;
            r_hs1     <= 1'b1;
            r_vs1     <= 1'b1;
        end else begin
            r_rd_addr <= w_de ? r_line_base + {{(C_ADDR_W-C_CNT_W+1){1'b0}}, w_col} : '0;
            r_en      <= w_de;
            r_de1     <= w_de;
            r_hs1     <= w_hsync;
            r_vs1     <= w_vsync;
        end
    end

    // Stage 2 covers the BRAM read; stage 3 captures its data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_de2 <= 1'b0;
            r_hs2 <= 1'b1;
            r_vs2 <= 1'b1;
            r_de3 <= 1'b0;
            r_hs3 <= 1'b1;
            r_vs3 <= 1'b1;
            r_rgb <= '0;
        end else begin
            r_de2 <= r_de1;
            r_hs2 <= r_hs1;
            r_vs2 <= r_vs1;
            r_de3 <= r_de2;
            r_hs3 <= r_hs2;
            r_vs3 <= r_vs2;
            r_rgb <= r_de2 ? bus.bram_rd_data : '0;
        end
    end

    assign bus.bram_rd_addr = r_rd_addr;
    assign bus.bram_en      = r_en;
    assign bus.vga_r        = r_rgb[C_R_LSB +: C_CH_W];
    assign bus.vga_g        = r_rgb[C_G_LSB +: C_CH_W];
    assign bus.vga_b        = r_rgb[C_B_LSB +: C_CH_W];
    assign bus.vga_de       = r_de3;
    assign bus.vga_hsync    = r_hs3;
    assign bus.vga_vsync    = r_vs3;
    assign bus.frame_start  = w_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_frame_reader
// Description : Self-checking bench: full-size instance for the first lines,
//               reduced-timing instance for frame wrap and mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_frame_reader;
    import vga_pkg::*;

    logic       clk;
    logic       rst_a;
    logic       rst_b;
    int         total;
    int         bad;
    int         mode_a;
    int         mode_b;
    logic [11:0] key_a;
    logic [11:0] key_b;

    int cfg_ha[2], cfg_hfp[2], cfg_hs[2], cfg_ht[2];
    int cfg_va[2], cfg_vfp[2], cfg_vs[2], cfg_vt[2], cfg_fbw[2];

    int   first_de, first_hs, second_hs, fs_count, max_addr, wrap_checks;
    logic prev_de, prev_hs, wrap_pend;

    vga_frame_reader_if bus_a ();
    vga_frame_reader_if bus_b ();

    vga_frame_reader u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    vga_frame_reader #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (2),
        .FB_WIDTH (8)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] pat(input int mode, input logic [11:0] key, input int addr);
        logic [31:0] a;
        a = addr;
        case (mode)
            0:       return a[11:0];
            1:       return 12'hFFF;
            default: begin
                a = a * 7;
                return a[11:0] ^ key;
            end
        endcase
    endfunction

    // Synchronous-read BRAM models, one cycle of latency.
    always @(posedge clk) if (bus_a.bram_en) bus_a.bram_rd_data <= pat(mode_a, key_a, int'(bus_a.bram_rd_addr));
    always @(posedge clk) if (bus_b.bram_en) bus_b.bram_rd_data <= pat(mode_b, key_b, int'(bus_b.bram_rd_addr));

    task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic get_obs(input int s, output logic [C_ADDR_W-1:0] addr, output logic en,
                           output logic de, output logic hs, output logic vs, output logic fs,
                           output logic [11:0] rgb);
        if (s == 0) begin
            addr = bus_a.bram_rd_addr; en = bus_a.bram_en; de = bus_a.vga_de;
            hs = bus_a.vga_hsync; vs = bus_a.vga_vsync; fs = bus_a.frame_start;
            rgb = {bus_a.vga_r, bus_a.vga_g, bus_a.vga_b};
        end else begin
            addr = bus_b.bram_rd_addr; en = bus_b.bram_en; de = bus_b.vga_de;
            hs = bus_b.vga_hsync; vs = bus_b.vga_vsync; fs = bus_b.frame_start;
            rgb = {bus_b.vga_r, bus_b.vga_g, bus_b.vga_b};
        end
    endtask

    task automatic check_reset(input int s, input int t);
        logic [C_ADDR_W-1:0] addr;
        logic en, de, hs, vs, fs;
        logic [11:0] rgb;
        get_obs(s, addr, en, de, hs, vs, fs, rgb);
        chk("rst_addr", t, 32'(addr), 0);
        chk("rst_en", t, 32'(en), 0);
        chk("rst_de", t, 32'(de), 0);
        chk("rst_hsync", t, 32'(hs), 1);
        chk("rst_vsync", t, 32'(vs), 1);
        chk("rst_frame_start", t, 32'(fs), 0);
        chk("rst_rgb", t, 32'(rgb), 0);
    endtask

    // Reference: t counts clocks since reset release; counters sit at (t mod H_TOTAL, ...).
    task automatic check_cycle(input int s, input int t);
        logic [C_ADDR_W-1:0] addr;
        logic en, de, hs, vs, fs;
        logic [11:0] rgb;
        int h, v, mode, e_en, e_addr, e_de, e_hs, e_vs, e_rgb;
        logic [11:0] key;
        get_obs(s, addr, en, de, hs, vs, fs, rgb);
        mode = (s == 0) ? mode_a : mode_b;
        key  = (s == 0) ? key_a : key_b;
        chk("frame_start", t, 32'(fs), ((t % (cfg_ht[s] * cfg_vt[s])) == 0) ? 1 : 0);
        e_en = 0; e_addr = 0;
        if (t >= 1) begin
            h = (t - 1) % cfg_ht[s];
            v = ((t - 1) / cfg_ht[s]) % cfg_vt[s];
            if (h < cfg_ha[s] && v < cfg_va[s]) begin
                e_en = 1;
                e_addr = (v / 2) * cfg_fbw[s] + h / 2;
            end
        end
        chk("bram_en", t, 32'(en), e_en);
        chk("bram_rd_addr", t, 32'(addr), e_addr);
        e_de = 0; e_hs = 1; e_vs = 1; e_rgb = 0;
        if (t >= 3) begin
            h = (t - 3) % cfg_ht[s];
            v = ((t - 3) / cfg_ht[s]) % cfg_vt[s];
            if (h >= cfg_ha[s] + cfg_hfp[s] && h < cfg_ha[s] + cfg_hfp[s] + cfg_hs[s]) e_hs = 0;
            if (v >= cfg_va[s] + cfg_vfp[s] && v < cfg_va[s] + cfg_vfp[s] + cfg_vs[s]) e_vs = 0;
            if (h < cfg_ha[s] && v < cfg_va[s]) begin
                e_de = 1;
                e_rgb = int'(pat(mode, key, (v / 2) * cfg_fbw[s] + h / 2));
            end
        end
        chk("vga_de", t, 32'(de), e_de);
        chk("vga_hsync", t, 32'(hs), e_hs);
        chk("vga_vsync", t, 32'(vs), e_vs);
        chk("vga_rgb", t, 32'(rgb), e_rgb);
    endtask

    task automatic track(input int s, input int t);
        logic [C_ADDR_W-1:0] addr;
        logic en, de, hs, vs, fs;
        logic [11:0] rgb;
        get_obs(s, addr, en, de, hs, vs, fs, rgb);
        if (s == 0) begin
            if (de && !prev_de && first_de < 0) first_de = t;
            if (!hs && prev_hs) begin
                if (first_hs < 0) first_hs = t;
                else if (second_hs < 0) second_hs = t;
            end
            prev_de = de;
            prev_hs = hs;
        end else begin
            if (fs) fs_count++;
            if (en) begin
                if (int'(addr) > max_addr) max_addr = int'(addr);
                if (wrap_pend) begin
                    chk("wrap_addr", t, 32'(addr), 0);
                    wrap_checks++;
                    wrap_pend = 1'b0;
                end
            end
            if (fs && t > 0) wrap_pend = 1'b1;
        end
    endtask

    task automatic run(input int s, input int n, inout int t);
        for (int i = 0; i < n; i++) begin
            check_cycle(s, t);
            track(s, t);
            @(negedge clk);
            #1;
            t++;
        end
    endtask

    initial begin
        int t;
        total = 0; bad = 0;
        cfg_ha  = '{640, 16}; cfg_hfp = '{16, 2}; cfg_hs = '{96, 3}; cfg_ht = '{800, 24};
        cfg_va  = '{480, 8};  cfg_vfp = '{10, 1}; cfg_vs = '{2, 2};  cfg_vt = '{525, 13};
        cfg_fbw = '{320, 8};
        mode_a = 0; key_a = 12'h000;
        mode_b = 2; key_b = 12'($urandom);
        first_de = -1; first_hs = -1; second_hs = -1;
        fs_count = 0; max_addr = -1; wrap_checks = 0;
        prev_de = 1'b0; prev_hs = 1'b1; wrap_pend = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        t = 0;

        repeat (3) @(negedge clk);
        #1;
        check_reset(0, -1);
        check_reset(1, -1);

        // Full-size timing, address-as-data pattern over the first three lines.
        @(negedge clk); rst_a = 1'b0; #1; t = 0;
        run(0, 2500, t);
        chk("first_de_rise", t, 32'(first_de), 3);
        chk("first_hsync_low", t, 32'(first_hs), 659);
        chk("line_period", t, 32'(second_hs - first_hs), 800);

        // Constant all-ones data: colour must still be zero throughout blanking.
        rst_a = 1'b1; #1;
        check_reset(0, t);
        mode_a = 1;
        @(negedge clk); rst_a = 1'b0; #1; t = 0;
        run(0, 1700, t);
        rst_a = 1'b1;

        // Reduced timing: three frames of random data, stopping at v=5, h=7 of frame four.
        @(negedge clk); rst_b = 1'b0; #1; t = 0;
        run(1, 3 * 312 + 5 * 24 + 7, t);
        chk("frame_start_count", t, 32'(fs_count), 4);
        chk("max_addr", t, 32'(max_addr), 31);
        chk("wrap_seen", t, (wrap_checks > 0) ? 1 : 0, 1);

        rst_b = 1'b1; #1;
        check_reset(1, t);
        repeat (5) begin
            @(negedge clk); #1;
            check_reset(1, t);
        end
        mode_b = 1;
        @(negedge clk); rst_b = 1'b0; #1; t = 0;
        run(1, 312 + 3 + 24, t);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
